// File: rtl/mc_control_unit_if.sv
// Control bus between the multicycle control unit (master) and the datapath/IR (slave).
// Carries the opcode and memory handshake in, and every datapath strobe out.
interface mc_control_unit_if #(
    parameter int OPW   = 6,
    parameter int ALUSW = 3
);
    logic [OPW-1:0]   opcode;
    logic             MemReady;
    logic             PCWriteCond;
    logic             PCWrite;
    logic             RegRead;
    logic             MemAddr;
    logic             MemWrite;
    logic             IRWrite;
    logic             ALUSrcA;
    logic             RegWrite;
    logic [1:0]       MemtoReg;
    logic [1:0]       BranchCond;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcB;
    logic [ALUSW-1:0] ALUSelect;
    logic             Illegal;
    logic [3:0]       State;

    modport master (
        input  opcode, MemReady,
        output PCWriteCond, PCWrite, RegRead, MemAddr, MemWrite, IRWrite, ALUSrcA,
               RegWrite, MemtoReg, BranchCond, PCSource, ALUSrcB, ALUSelect, Illegal, State
    );

    modport slave (
        output opcode, MemReady,
        input  PCWriteCond, PCWrite, RegRead, MemAddr, MemWrite, IRWrite, ALUSrcA,
               RegWrite, MemtoReg, BranchCond, PCSource, ALUSrcB, ALUSelect, Illegal, State
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle CPU control unit: Moore FSM with MemReady wait states and ALU-select decode.
// Define MCCTRL_TRAP_EN to trap illegal opcodes; otherwise they execute as a 2-cycle NOP.
module mc_control_unit #(
    parameter int OPW   = 6,
    parameter int ALUSW = 3
) (
    input  logic                Clk,
    input  logic                Reset_n,
    mc_control_unit_if.master   bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
`ifdef MCCTRL_TRAP_EN
        JUMP   = 4'd9,
        TRAP   = 4'd10
`else
        JUMP   = 4'd9
`endif
    } state_t;

    state_t state;

    // Opcode class decode; any set bit above [5] makes the opcode illegal.
    logic       hiZero;
    logic [5:0] op;
    logic       isReg, isImm, isLw, isSw, isBeq, isBne, isJ;

    assign hiZero = ((bus.opcode >> 6) == '0);
    assign op     = bus.opcode[5:0];
    assign isReg  = hiZero && (op[5:3] == 3'b000);
    assign isImm  = hiZero && (op[5:3] == 3'b001);
    assign isLw   = hiZero && (op == 6'h10);
    assign isSw   = hiZero && (op == 6'h11);
    assign isBeq  = hiZero && (op == 6'h12);
    assign isBne  = hiZero && (op == 6'h13);
    assign isJ    = hiZero && (op == 6'h14);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (bus.MemReady) state <= DECODE;
                DECODE: begin
                    if (isReg || isImm)      state <= EXEC;
                    else if (isLw || isSw)   state <= MEMADR;
                    else if (isBeq || isBne) state <= BRANCH;
                    else if (isJ)            state <= JUMP;
`ifdef MCCTRL_TRAP_EN
                    else                     state <= TRAP;
`else
                    else                     state <= FETCH;
`endif
                end
                MEMADR:  state <= isLw ? MEMRD : MEMWR;
                MEMRD:   if (bus.MemReady) state <= MEMWB;
                MEMWR:   if (bus.MemReady) state <= FETCH;
                EXEC:    state <= ALUWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.PCWriteCond = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.RegRead     = 1'b0;
        bus.MemAddr     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.BranchCond  = 2'b00;
        bus.PCSource    = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUSelect   = '0;
        bus.Illegal     = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
            end
            DECODE: begin
                bus.RegRead = 1'b1;
                bus.ALUSrcB = 2'b11;
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD:  bus.MemAddr = 1'b1;
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b01;
            end
            MEMWR: begin
                bus.MemAddr  = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = isImm ? 2'b10 : 2'b00;
                bus.ALUSelect = ALUSW'(op[2:0]);
            end
            ALUWB:  bus.RegWrite = 1'b1;
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSelect   = ALUSW'(1);
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchCond  = isBne ? 2'b01 : 2'b00;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
`ifdef MCCTRL_TRAP_EN
            TRAP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b11;
                bus.Illegal  = 1'b1;
            end
`endif
            default: ;
        endcase
        // Write strobes stay off while reset is held, even though FETCH follows MemReady.
        if (!Reset_n) begin
            bus.IRWrite = 1'b0;
            bus.PCWrite = 1'b0;
            bus.Illegal = 1'b0;
        end
    end

    assign bus.State = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed, table-driven bench for mc_control_unit: per-cycle state and strobe vectors
// plus a hand-written mid-instruction reset sequence.
module tb_mc_control_unit;

    logic Clk;
    logic Reset_n;
    int   checks;
    int   failures;

    mc_control_unit_if #(.OPW(6), .ALUSW(3)) bus ();

    mc_control_unit #(.OPW(6), .ALUSW(3)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [19:0] ctl;
    } vec_t;

    vec_t vecs[$];

    // {PCWriteCond,PCWrite,RegRead,MemAddr,MemWrite,IRWrite,ALUSrcA,RegWrite,
    //  MemtoReg,BranchCond,PCSource,ALUSrcB,ALUSelect,Illegal}
    function automatic logic [19:0] cw(input logic pcwc, input logic pcw, input logic rr,
                                       input logic ma, input logic mw, input logic irw,
                                       input logic asa, input logic rw, input logic [1:0] m2r,
                                       input logic [1:0] bc, input logic [1:0] pcs,
                                       input logic [1:0] asb, input logic [2:0] sel,
                                       input logic ill);
        return {pcwc, pcw, rr, ma, mw, irw, asa, rw, m2r, bc, pcs, asb, sel, ill};
    endfunction

    function automatic logic [19:0] actual();
        return {bus.PCWriteCond, bus.PCWrite, bus.RegRead, bus.MemAddr, bus.MemWrite,
                bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.MemtoReg, bus.BranchCond,
                bus.PCSource, bus.ALUSrcB, bus.ALUSelect, bus.Illegal};
    endfunction

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [19:0] ctl);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic checkVal(input string name, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    logic [19:0] F1, F0, DEC, MADR, MRD, MWB, MWR, EXI3, EXR5, AWB, BNEW, BEQW, JMP, TRP;

    initial begin
        checks   = 0;
        failures = 0;

        F1   = cw(0,1,0,0,0,1,0,0, 2'd0,2'd0,2'd0,2'd1, 3'd0,0);
        F0   = cw(0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd1, 3'd0,0);
        DEC  = cw(0,0,1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3, 3'd0,0);
        MADR = cw(0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd2, 3'd0,0);
        MRD  = cw(0,0,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,0);
        MWB  = cw(0,0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 3'd0,0);
        MWR  = cw(0,0,0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,0);
        EXI3 = cw(0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd2, 3'd3,0);
        EXR5 = cw(0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0, 3'd5,0);
        AWB  = cw(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 3'd0,0);
        BNEW = cw(1,0,0,0,0,0,1,0, 2'd0,2'd1,2'd1,2'd0, 3'd1,0);
        BEQW = cw(1,0,0,0,0,0,1,0, 2'd0,2'd0,2'd1,2'd0, 3'd1,0);
        JMP  = cw(0,1,0,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0, 3'd0,0);
        TRP  = cw(0,1,0,0,0,0,0,0, 2'd0,2'd0,2'd3,2'd0, 3'd0,1);

        // Immediate ALU op 0x0B
        add(6'h0B, 1, 4'd0, F1);
        add(6'h0B, 1, 4'd1, DEC);
        add(6'h0B, 1, 4'd6, EXI3);
        add(6'h0B, 1, 4'd7, AWB);
        // LW with two wait states in MEMRD
        add(6'h10, 1, 4'd0, F1);
        add(6'h10, 1, 4'd1, DEC);
        add(6'h10, 1, 4'd2, MADR);
        add(6'h10, 0, 4'd3, MRD);
        add(6'h10, 0, 4'd3, MRD);
        add(6'h10, 1, 4'd3, MRD);
        add(6'h10, 1, 4'd4, MWB);
        // SW with one wait state in FETCH and one in MEMWR
        add(6'h11, 0, 4'd0, F0);
        add(6'h11, 1, 4'd0, F1);
        add(6'h11, 1, 4'd1, DEC);
        add(6'h11, 1, 4'd2, MADR);
        add(6'h11, 0, 4'd5, MWR);
        add(6'h11, 1, 4'd5, MWR);
        // BNE, MemReady low where it must be ignored
        add(6'h13, 1, 4'd0, F1);
        add(6'h13, 0, 4'd1, DEC);
        add(6'h13, 0, 4'd8, BNEW);
        // BEQ
        add(6'h12, 1, 4'd0, F1);
        add(6'h12, 1, 4'd1, DEC);
        add(6'h12, 1, 4'd8, BEQW);
        // J, MemReady low in JUMP
        add(6'h14, 1, 4'd0, F1);
        add(6'h14, 1, 4'd1, DEC);
        add(6'h14, 0, 4'd9, JMP);
        // Register ALU op 0x05, MemReady low in EXEC/ALUWB
        add(6'h05, 1, 4'd0, F1);
        add(6'h05, 1, 4'd1, DEC);
        add(6'h05, 0, 4'd6, EXR5);
        add(6'h05, 0, 4'd7, AWB);
        // Illegal opcode
        add(6'h3F, 1, 4'd0, F1);
        add(6'h3F, 1, 4'd1, DEC);
`ifdef MCCTRL_TRAP_EN
        add(6'h3F, 1, 4'd10, TRP);
`endif
        add(6'h00, 0, 4'd0, F0);

        // Reset state
        Reset_n      = 1'b0;
        bus.opcode   = 6'h00;
        bus.MemReady = 1'b1;
        @(negedge Clk);
        #1;
        checkVal("reset_state", 20'(bus.State), 20'd0);
        checkVal("reset_ctl", actual(), F0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.opcode   = vecs[i].op;
            bus.MemReady = vecs[i].mr;
            #1;
            checkVal($sformatf("vec%0d_state", i), 20'(bus.State), 20'(vecs[i].st));
            checkVal($sformatf("vec%0d_ctl", i), actual(), vecs[i].ctl);
            @(negedge Clk);
        end

        // Reset asserted mid-EXEC aborts the instruction
        bus.opcode   = 6'h0B;
        bus.MemReady = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        checkVal("pre_reset_exec", 20'(bus.State), 20'd6);
        Reset_n = 1'b0;
        #1;
        checkVal("midreset_state", 20'(bus.State), 20'd0);
        checkVal("midreset_ctl", actual(), F0);
        @(negedge Clk);
        #1;
        checkVal("held_reset_ctl", actual(), F0);
        Reset_n = 1'b1;
        #1;
        checkVal("release_state", 20'(bus.State), 20'd0);
        checkVal("release_ctl", actual(), F1);
        @(negedge Clk);
        #1;
        checkVal("post_release_state", 20'(bus.State), 20'd1);
        checkVal("post_release_ctl", actual(), DEC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multicycle CPU control unit: one Moore FSM plus an integrated ALU-select decoder. It drives every datapath control strobe of the multicycle core, sequencing fetch, decode, execute, memory and write-back. It generalises the earlier controller in three ways: configurable opcode and ALU-select widths, memory wait-state handshaking via `MemReady`, and optional illegal-opcode trapping. It sits between the instruction register (opcode source) and the datapath.

## Interface
- `OPW`, 6: opcode width (≥6). Bits above [5] must be zero for a legal opcode.
- `ALUSW`, 3: ALUSelect width (≥3). Upper bits are zero-filled.
- `Clk`  in  1  clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  OPW  from IR; stable from DECODE to end of instruction.
- `MemReady`  in  1  memory completes the current access this cycle.
- `PCWriteCond, PCWrite, RegRead, MemAddr, MemWrite, IRWrite, ALUSrcA, RegWrite`  out  1 each.
- `MemtoReg, BranchCond, PCSource, ALUSrcB`  out  2 each.
- `ALUSelect`  out  ALUSW.
- `Illegal`  out  1  illegal-opcode trap strobe.
- `State`  out  4  current state, for debug.

## Operation
- Opcode classes:
  - `0x00–0x07`: register ALU op.
  - `0x08–0x0F`: immediate ALU op.
  - `0x10`: LW. `0x11`: SW. `0x12`: BEQ. `0x13`: BNE. `0x14`: J.
  - All other values are illegal.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, TRAP=10.
- Outputs are decoded combinationally from state, plus opcode and MemReady where noted. Any output not listed for a state is 0.
  - FETCH: ALUSrcB=01, ALUSelect=0 (ADD), IRWrite=PCWrite=MemReady. Holds while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: RegRead=1, ALUSrcB=11, ALUSelect=0. Next state by class: ALU ops → EXEC; LW/SW → MEMADR; BEQ/BNE → BRANCH; J → JUMP; illegal → TRAP.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUSelect=0. LW → MEMRD; SW → MEMWR.
  - MEMRD: MemAddr=1. Holds until MemReady=1, then goes to MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=01. Goes to FETCH.
  - MEMWR: MemAddr=1, MemWrite=1, held for the whole access. Goes to FETCH on MemReady=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00 (register class) or 10 (immediate class), ALUSelect=zero-extended opcode[2:0]. Goes to ALUWB.
  - ALUWB: RegWrite=1, MemtoReg=00. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSelect=1 (SUB), PCWriteCond=1, PCSource=01, BranchCond=00 (BEQ) or 01 (BNE). Goes to FETCH.
  - JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
  - TRAP: PCWrite=1, PCSource=11, Illegal=1. Goes to FETCH.
- Reset: while Reset_n=0, State=FETCH and IRWrite, PCWrite and Illegal are forced to 0. All other outputs take their FETCH values.
- Reset asserted mid-instruction aborts the instruction immediately. No partial write strobe may follow reset release before the next FETCH completes.

## Timing
- Zero-wait latencies:
  - ALU op: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE, J, trap: 3 cycles each.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- MemReady is ignored in every other state.
- IRWrite and PCWrite in FETCH are high for exactly one cycle per instruction.
- Illegal is high for exactly one cycle per trap.
- Reset release takes effect on the first rising Clk edge with Reset_n=1.

## Configuration
- `MCCTRL_TRAP_EN`:
  - Defined: illegal opcodes go DECODE→TRAP as described above.
  - Undefined: TRAP does not exist; illegal opcodes go DECODE→FETCH (NOP, 2 cycles), and Illegal is tied 0.

## Test plan
- Reset_n=0 mid-EXEC, then released, MemReady=1 → State=0. IRWrite/PCWrite are 0 during reset and 1 in the first cycle after release.
- opcode=0x0B, MemReady=1 → State sequence 0,1,6,7,0. In EXEC: ALUSrcB=10, ALUSelect=3'b011. RegWrite=1 only in ALUWB.
- LW (0x10) with MemReady=0 for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0 (7 cycles). MemtoReg=01 in MEMWB.
- SW (0x11) with MemReady low for 1 cycle in FETCH → FETCH held for 2 cycles with IRWrite high only in its final cycle. MemWrite is high in both MEMWR cycles when MemReady is low for 1 cycle there.
- BNE (0x13) → BRANCH state with PCWriteCond=1, PCSource=01, BranchCond=01, ALUSelect=1.
- opcode=0x3F → with `MCCTRL_TRAP_EN`: sequence 0,1,10,0, Illegal and PCWrite high in TRAP, PCSource=11. Without it: sequence 0,1,0, Illegal never high.
